dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port data memory between the processor's MEM stage (port 0) and a debug/display scanner (port 1). It issues at most one memory access per cycle, routes synchronous read data back to the requester that owns it, and asserts a stall to the processor when port 0 loses arbitration. It sits between `TopProcessor`'s MEM stage and the data memory instance.

---
 rtl/dmem_arbiter.sv | 103 ++++++++++
 tb/tb_dmem_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the MEM stage (port 0) and a scanner (port 1).
// Optional build macro DMEM_ARB_RR_EN selects round-robin arbitration in place of port-0 priority with starvation guard.
`default_nettype none

module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2
  } rd_state_t;

  rd_state_t state;
  logic      p1_wins;

`ifdef DMEM_ARB_RR_EN
  // last = 1 means port 1 was granted most recently, so port 0 wins the next conflict
  logic last;

  assign p1_wins = ~last;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      last <= 1'b1;
    end else if (p0_gnt || p1_gnt) begin
      last <= p1_gnt;
    end
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;

  assign p1_wins = (starve_cnt == STARVE_LIM);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      starve_cnt <= 4'd0;
    end else if (!p1_req || p1_gnt) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`endif

  // Grants are suppressed while Reset is high so no access slips through mid-reset
  assign p0_gnt    = ~Reset & p0_req & (~p1_req | ~p1_wins);
  assign p1_gnt    = ~Reset & p1_req & (~p0_req |  p1_wins);
  assign cpu_stall = p0_req & ~p0_gnt;

  assign mem_en    = p0_gnt | p1_gnt;
  assign mem_we    = p1_gnt ? p1_we    : (p0_gnt & p0_we);
  assign mem_addr  = p1_gnt ? p1_addr  : p0_addr;
  assign mem_wdata = p1_gnt ? p1_wdata : p0_wdata;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else if (p0_gnt && !p0_we) begin
      state <= RD0;
    end else if (p1_gnt && !p1_we) begin
      state <= RD1;
    end else begin
      state <= IDLE;
    end
  end

  assign p0_rvalid = (state == RD0);
  assign p1_rvalid = (state == RD1);
  assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
  assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed vector table plus starvation/round-robin and reset-mid-read sequences.
`default_nettype none

module tb_dmem_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
    .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
  );

  // Synchronous single-port memory: read data appears one cycle after mem_en
  logic [31:0] mem [0:255];
  always @(posedge Clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  typedef struct {
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic        g0, g1, men, mwe;
    logic [31:0] maddr;
    logic        stall, rv0, rv1;
    logic [31:0] rd0, rd1;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
  endtask

  function automatic vec_t mk(logic r0, logic w0, logic [31:0] a0, logic [31:0] d0,
                              logic r1, logic w1, logic [31:0] a1, logic [31:0] d1,
                              logic g0, logic g1, logic men, logic mwe, logic [31:0] maddr,
                              logic stall, logic rv0, logic [31:0] rd0, logic rv1, logic [31:0] rd1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.men = men; v.mwe = mwe; v.maddr = maddr;
    v.stall = stall; v.rv0 = rv0; v.rd0 = rd0; v.rv1 = rv1; v.rd1 = rd1;
    return v;
  endfunction

  initial begin
    logic exp_p1;
    logic prev_p1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h30] = 32'hA5A50001;
    mem_rdata = 32'h0;

    //          r0 w0 a0     d0            r1 w1 a1     d1            g0 g1 en we addr   st rv0 rd0           rv1 rd1
    vecs[0] = mk(1, 0, 32'h10, 32'h0,        0, 0, 32'h0,  32'h0,        1, 0, 1, 0, 32'h10, 0, 0, 32'h0,        0, 32'h0);
    vecs[1] = mk(0, 0, 32'h0,  32'h0,        1, 1, 32'h20, 32'h12345678, 0, 1, 1, 1, 32'h20, 0, 1, 32'hDEADBEEF, 0, 32'h0);
    vecs[2] = mk(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 32'h0,  0, 0, 32'h0,        0, 32'h0);
    vecs[3] = mk(1, 0, 32'h10, 32'h0,        0, 0, 32'h0,  32'h0,        1, 0, 1, 0, 32'h10, 0, 0, 32'h0,        0, 32'h0);
    vecs[4] = mk(0, 0, 32'h0,  32'h0,        1, 0, 32'h20, 32'h0,        0, 1, 1, 0, 32'h20, 0, 1, 32'hDEADBEEF, 0, 32'h0);
    vecs[5] = mk(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 32'h0,  0, 0, 32'h0,        1, 32'h12345678);
    vecs[6] = mk(1, 1, 32'h30, 32'h11111111, 1, 0, 32'h10, 32'h0,        1, 0, 1, 1, 32'h30, 0, 0, 32'h0,        0, 32'h0);
    vecs[7] = mk(0, 0, 32'h0,  32'h0,        1, 0, 32'h10, 32'h0,        0, 1, 1, 0, 32'h10, 0, 0, 32'h0,        0, 32'h0);
    vecs[8] = mk(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 32'h0,  0, 0, 32'h0,        1, 32'hDEADBEEF);

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    Reset = 1'b1;
    #200;
    check("rst_p0_gnt",    {31'b0, p0_gnt},    32'h0);
    check("rst_mem_en",    {31'b0, mem_en},    32'h0);
    check("rst_p0_rvalid", {31'b0, p0_rvalid}, 32'h0);
    check("rst_p1_rvalid", {31'b0, p1_rvalid}, 32'h0);
    check("rst_p0_rdata",  p0_rdata,           32'h0);
    check("rst_p1_rdata",  p1_rdata,           32'h0);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      @(posedge Clk); #1;
      drive(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0, vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
      @(negedge Clk);
      check($sformatf("v%0d_p0_gnt", i),    {31'b0, p0_gnt},    {31'b0, vecs[i].g0});
      check($sformatf("v%0d_p1_gnt", i),    {31'b0, p1_gnt},    {31'b0, vecs[i].g1});
      check($sformatf("v%0d_mem_en", i),    {31'b0, mem_en},    {31'b0, vecs[i].men});
      check($sformatf("v%0d_mem_we", i),    {31'b0, mem_we},    {31'b0, vecs[i].mwe});
      if (vecs[i].men) check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].maddr);
      check($sformatf("v%0d_stall", i),     {31'b0, cpu_stall}, {31'b0, vecs[i].stall});
      check($sformatf("v%0d_p0_rvalid", i), {31'b0, p0_rvalid}, {31'b0, vecs[i].rv0});
      check($sformatf("v%0d_p1_rvalid", i), {31'b0, p1_rvalid}, {31'b0, vecs[i].rv1});
      check($sformatf("v%0d_p0_rdata", i),  p0_rdata,           vecs[i].rd0);
      check($sformatf("v%0d_p1_rdata", i),  p1_rdata,           vecs[i].rd1);
    end

    // Continuous conflict: p0 reads 0x10, p1 reads 0x30 (0x11111111 after vector 6)
    prev_p1 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge Clk); #1;
      drive(1, 0, 32'h10, 0, 1, 0, 32'h30, 0);
      @(negedge Clk);
`ifdef DMEM_ARB_RR_EN
      exp_p1 = (i % 2 == 1);
`else
      exp_p1 = (i % 5 == 4);
`endif
      check($sformatf("sv%0d_p0_gnt", i), {31'b0, p0_gnt},    {31'b0, ~exp_p1});
      check($sformatf("sv%0d_p1_gnt", i), {31'b0, p1_gnt},    {31'b0, exp_p1});
      check($sformatf("sv%0d_stall", i),  {31'b0, cpu_stall}, {31'b0, exp_p1});
      if (i > 0) begin
        check($sformatf("sv%0d_p0_rvalid", i), {31'b0, p0_rvalid}, {31'b0, ~prev_p1});
        check($sformatf("sv%0d_p1_rvalid", i), {31'b0, p1_rvalid}, {31'b0, prev_p1});
        check($sformatf("sv%0d_rdata", i), prev_p1 ? p1_rdata : p0_rdata,
              prev_p1 ? 32'h11111111 : 32'hDEADBEEF);
      end
      prev_p1 = exp_p1;
    end

    // Reset one cycle after a p1 read grant drops the pending rvalid
    @(posedge Clk); #1;
    drive(0, 0, 0, 0, 1, 0, 32'h20, 0);
    @(negedge Clk);
    check("rr_p1_gnt", {31'b0, p1_gnt}, 32'h1);
    @(posedge Clk); #1;
    drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
    Reset = 1'b1;
    #1;
    check("rr_p1_rvalid", {31'b0, p1_rvalid}, 32'h0);
    check("rr_p1_rdata",  p1_rdata,           32'h0);
    check("rr_p0_gnt",    {31'b0, p0_gnt},    32'h0);
    check("rr_mem_en",    {31'b0, mem_en},    32'h0);
    check("rr_stall",     {31'b0, cpu_stall}, 32'h1);
    @(negedge Clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    Reset = 1'b0;
    @(posedge Clk); #1;
    drive(1, 0, 32'h10, 0, 1, 0, 32'h30, 0);
    @(negedge Clk);
    check("post_rst_p1_rvalid", {31'b0, p1_rvalid}, 32'h0);
    check("post_rst_p0_gnt",    {31'b0, p0_gnt},    32'h1);
    check("post_rst_p1_gnt",    {31'b0, p1_gnt},    32'h0);
    @(posedge Clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    check("post_rst_p0_rdata", p0_rdata, 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
